divider_sd: RTL and testbench
=============================

# divider_sd

Parametrised iterative integer divider handling both signed and unsigned operands in one block, selected per operation by a mode input. It computes one radix-2 restoring step per clock and uses a start/busy/done handshake. Divide-by-zero and signed-overflow results are defined. It sits beside the ALU as the multi-cycle execution unit for DIV/DIVU/REM/REMU and stalls the pipeline through `busy`.

## Interface
- WIDTH, 32, operand and result width in bits; must be ≥ 2.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state and outputs.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
- dividend  in  WIDTH  sampled with start.
- divisor  in  WIDTH  sampled with start.
- q  out  WIDTH  quotient, registered.
- r  out  WIDTH  remainder, registered.
- busy  out  1  high from the cycle after accepted start until the result edge.
- done  out  1  one-cycle pulse coincident with new q/r.
- div_zero  out  1  set with done when divisor was 0; held until next accepted start.

## Operation
- States: IDLE, RUN, FIX.
- IDLE with start=1: latch the operands.
  - Unsigned magnitudes are the raw values.
  - Signed magnitudes are abs(dividend) and abs(divisor) as WIDTH-bit unsigned.
  - Latch neg_q = is_signed & (sign(dividend) ^ sign(divisor)) and neg_r = is_signed & sign(dividend).
  - Clear counter to 0. Set busy. Clear div_zero.
  - Go to RUN, or to FIX directly if divisor == 0.
- RUN: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude from rem using a WIDTH+1-bit subtractor.
  - If the result is non-negative, keep it and set the quotient LSB; otherwise restore.
  - Counter increments each step. After step WIDTH, go to FIX.
- FIX: write the outputs, clear busy, pulse done, return to IDLE.
  - q = neg_q ? -quo : quo
  - r = neg_r ? -rem : rem
- Divide by zero (either mode): q = all ones, r = original dividend, div_zero = 1.
- Signed overflow, MIN / -1: q = MIN, r = 0, div_zero = 0. This falls out of the magnitude arithmetic and needs no special case.
- Quotient rounds toward zero. Remainder takes the sign of the dividend.
- `start` while busy is ignored. Operand and mode changes while busy have no effect.
- q/r hold their last value until the next done. div_zero holds until the next accepted start.

## Timing
- Reset (asynchronous, while low):
  - q = 0, r = 0, busy = 0, done = 0, div_zero = 0.
  - State returns to IDLE and the counter clears.
  - Reset asserted mid-operation aborts it with no done pulse.
- Edge E0: start is accepted; busy = 1 after E0.
- Normal op: RUN steps occupy edges E1..E_WIDTH. Edge E_(WIDTH+1) writes q/r, sets done = 1 and busy = 0.
  - Latency is WIDTH+1 cycles (33 for WIDTH = 32).
- Divide by zero: results are written at E1 with done = 1 and busy = 0. Latency is 1 cycle.
- done is high for exactly one cycle.
- A start held high into the IDLE cycle after done is accepted. Back-to-back throughput is WIDTH+2 cycles per divide.

## Test plan
- WIDTH = 32, unsigned, 0xFFFFFFFF / 0x2 → q = 0x7FFFFFFF, r = 0x1, done exactly 33 cycles after the start edge, busy high 33 cycles.
- Same operands, signed (-1 / 2) → q = 0x00000000, r = 0xFFFFFFFF.
- 0xAAAAAAAA / 0x55555555:
  - unsigned → q = 0x2, r = 0x0.
  - signed → q = 0xFFFFFFFF, r = 0xFFFFFFFF.
- Edge cases, signed and unsigned:
  - 0x12345678 / 0 → q = 0xFFFFFFFF, r = 0x12345678, div_zero = 1, done 1 cycle after start.
  - Signed 0x80000000 / 0xFFFFFFFF → q = 0x80000000, r = 0, div_zero = 0.
- Handshake:
  - Pulse start again at cycle 10 of an operation with different operands → ignored; the original result appears on schedule.
  - Assert reset low at cycle 15 → all outputs 0 immediately, no done.
  - A new start after reset completes correctly.
- WIDTH = 8 instance:
  - signed 0xF9 / 0x02 (-7 / 2) → q = 0xFD, r = 0xFF, latency 9 cycles.
  - unsigned 0xF9 / 0x02 → q = 0x7C, r = 0x01.

Source files
------------

// File: rtl/divider_sd.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// divider_sd
//   Iterative radix-2 restoring integer divider. It handles signed
//   (two's-complement) and unsigned operands, selected for each operation.
//   It computes one quotient bit per clock. The core always divides
//   magnitudes, and signs are applied in a final fix-up cycle. Divide by zero
//   returns q = all ones and r = the dividend, and raises div_zero.
//   Signed MIN / -1 gives q = MIN and r = 0 without any special handling.
//
//   Latency: WIDTH+1 cycles from the start edge to done.
//            1 cycle for divide by zero.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset; clears all state and outputs
//   start_i      request, sampled only while idle
//   is_signed_i  1 = signed divide, 0 = unsigned (sampled with start_i)
//   dividend_i   dividend (sampled with start_i)
//   divisor_i    divisor  (sampled with start_i)
//   q_o          quotient, registered, held until the next done
//   r_o          remainder, registered, held until the next done
//   busy_o       high from the cycle after an accepted start until the result edge
//   done_o       one-cycle pulse coincident with new q_o/r_o
//   div_zero_o   set with done_o on divide by zero, held until the next accepted start
// -----------------------------------------------------------------------------
module divider_sd #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o
);

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Two's-complement negate when neg is set.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                              input logic             neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Magnitude of an operand as an unsigned WIDTH-bit value. abs(MIN) wraps
  // to MIN, which is the correct unsigned magnitude 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic                    sgn);
    return neg_if(v, sgn & v[WIDTH-1]);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic signed [WIDTH-1:0] dividend_s;
  logic signed [WIDTH-1:0] divisor_s;
  logic                    dvd_neg;
  logic                    dvs_neg;

  // Partial remainder after the left shift of {rem, quo}, and the trial
  // difference. The extra top bit is the borrow. Because rem < divisor
  // always holds, a non-negative trial always fits back into WIDTH bits.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  assign dividend_s = dividend_i;
  assign divisor_s  = divisor_i;
  assign dvd_neg    = is_signed_i & dividend_s[WIDTH-1];
  assign dvs_neg    = is_signed_i & divisor_s[WIDTH-1];

  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    q_d        = q_q;
    r_d        = r_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      // Accept: latch magnitudes and result signs.
      S_IDLE: begin
        if (start_i) begin
          rem_d      = '0;
          quo_d      = mag(dividend_s, is_signed_i);
          dvs_d      = mag(divisor_s, is_signed_i);
          neg_quo_d  = dvd_neg ^ dvs_neg;
          neg_rem_d  = dvd_neg;
          dz_d       = (divisor_i == '0);
          cnt_d      = '0;
          busy_d     = 1'b1;
          div_zero_d = 1'b0;
          state_d    = (divisor_i == '0) ? S_FIX : S_RUN;
        end
      end

      // One restoring step per cycle.
      S_RUN: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = S_FIX;
        end
      end

      // Sign fix-up and result write.
      S_FIX: begin
        if (dz_q) begin
          // quo still holds the dividend magnitude. Re-applying the dividend
          // sign restores the original dividend bits.
          q_d        = '1;
          r_d        = neg_if(quo_q, neg_rem_q);
          div_zero_d = 1'b1;
        end else begin
          q_d = neg_if(quo_q, neg_quo_q);
          r_d = neg_if(rem_q, neg_rem_q);
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      q_q        <= q_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign q_o        = q_q;
  assign r_o        = r_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_divider_sd.sv
`timescale 1ns/1ps
module tb_divider_sd;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start32 = 1'b0, sgn32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [31:0] q32, r32;
  logic        busy32, done32, dz32;

  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [7:0]  q8, r8;
  logic        busy8, done8, dz8;

  divider_sd #(.WIDTH(32)) u_div32 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start32), .is_signed_i(sgn32),
    .dividend_i(a32), .divisor_i(b32), .q_o(q32), .r_o(r32),
    .busy_o(busy32), .done_o(done32), .div_zero_o(dz32)
  );

  divider_sd #(.WIDTH(8)) u_div8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .is_signed_i(sgn8),
    .dividend_i(a8), .divisor_i(b8), .q_o(q8), .r_o(r8),
    .busy_o(busy8), .done_o(done8), .div_zero_o(dz8)
  );

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic [31:0] lat;
    logic [63:0] t0;
    logic [15:0] id;
  } exp_t;

  exp_t exp32_q[$];
  exp_t exp8_q[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input logic [31:0] aq,
                       input logic [31:0] ar, input logic adz, input int lat, input int bcnt);
    chk($sformatf("%s#%0d q", tag, e.id), aq, e.q);
    chk($sformatf("%s#%0d r", tag, e.id), ar, e.r);
    chk($sformatf("%s#%0d div_zero", tag, e.id), {31'b0, adz}, {31'b0, e.dz});
    chk($sformatf("%s#%0d latency", tag, e.id), 32'(lat), e.lat);
    chk($sformatf("%s#%0d busy_cycles", tag, e.id), 32'(bcnt), e.lat);
  endtask

  // Monitor for the 32-bit instance.
  initial begin
    int     bcnt = 0;
    logic   dprev = 1'b0;
    exp_t   e;
    longint td;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt  = 0;
        dprev = 1'b0;
      end else begin
        if (busy32 === 1'b1) bcnt++;
        if (done32 === 1'b1) begin
          chk("div32 done_width", {31'b0, dprev}, 32'd0);
          chk("div32 busy_at_done", {31'b0, busy32}, 32'd0);
          if (exp32_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL div32 unexpected_done: got q=%h r=%h, required no done", q32, r32);
          end else begin
            e  = exp32_q.pop_front();
            td = longint'($time) - 5;
            score("div32", e, q32, r32, dz32, int'((td - longint'(e.t0)) / 10), bcnt);
          end
          bcnt = 0;
        end
        dprev = done32;
      end
    end
  end

  // Monitor for the 8-bit instance.
  initial begin
    int     bcnt = 0;
    logic   dprev = 1'b0;
    exp_t   e;
    longint td;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt  = 0;
        dprev = 1'b0;
      end else begin
        if (busy8 === 1'b1) bcnt++;
        if (done8 === 1'b1) begin
          chk("div8 done_width", {31'b0, dprev}, 32'd0);
          chk("div8 busy_at_done", {31'b0, busy8}, 32'd0);
          if (exp8_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL div8 unexpected_done: got q=%h r=%h, required no done", q8, r8);
          end else begin
            e  = exp8_q.pop_front();
            td = longint'($time) - 5;
            score("div8", e, {24'b0, q8}, {24'b0, r8}, dz8, int'((td - longint'(e.t0)) / 10), bcnt);
          end
          bcnt = 0;
        end
        dprev = done8;
      end
    end
  end

  task automatic issue32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input logic push, input logic [15:0] id);
    exp_t e;
    @(negedge clk);
    sgn32 = sgn; a32 = a; b32 = b; start32 = 1'b1;
    @(posedge clk);
    if (push) begin
      e.q = eq; e.r = er; e.dz = edz; e.lat = edz ? 32'd1 : 32'd33;
      e.t0 = 64'($time); e.id = id;
      exp32_q.push_back(e);
    end
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic issue8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz,
                        input logic [15:0] id);
    exp_t e;
    @(negedge clk);
    sgn8 = sgn; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk);
    e.q = {24'b0, eq}; e.r = {24'b0, er}; e.dz = edz; e.lat = edz ? 32'd1 : 32'd9;
    e.t0 = 64'($time); e.id = id;
    exp8_q.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done32(input string nm);
    int k = 0;
    while (done32 !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_vec++; n_bad++;
      $display("FAIL %s timeout: got no done in 200 cycles, required done", nm);
    end
  endtask

  task automatic wait_done8(input string nm);
    int k = 0;
    while (done8 !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_vec++; n_bad++;
      $display("FAIL %s timeout: got no done in 200 cycles, required done", nm);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " q32"}, q32, 32'd0);
    chk({tag, " r32"}, r32, 32'd0);
    chk({tag, " busy32"}, {31'b0, busy32}, 32'd0);
    chk({tag, " done32"}, {31'b0, done32}, 32'd0);
    chk({tag, " dz32"}, {31'b0, dz32}, 32'd0);
    chk({tag, " q8"}, {24'b0, q8}, 32'd0);
    chk({tag, " r8"}, {24'b0, r8}, 32'd0);
    chk({tag, " busy8"}, {31'b0, busy8}, 32'd0);
  endtask

  initial begin
    exp_t e;
    #1 rst_n = 1'b0;
    #1 chk_rst("reset_init");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Unsigned 0xFFFFFFFF / 2; a second start at cycle 10 must be ignored.
    issue32(1'b0, 32'hFFFF_FFFF, 32'h2, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 16'd1);
    repeat (8) @(negedge clk);
    sgn32 = 1'b1; a32 = 32'd5; b32 = 32'd1; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    wait_done32("t1");

    issue32(1'b1, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1, 16'd2);
    wait_done32("t2");
    issue32(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'h2, 32'h0, 1'b0, 1'b1, 16'd3);
    wait_done32("t3");
    issue32(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 16'd4);
    wait_done32("t4");
    issue32(1'b0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b1, 16'd5);
    wait_done32("t5");
    issue32(1'b1, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b1, 16'd6);
    wait_done32("t6");
    issue32(1'b1, 32'h8765_4321, 32'h0, 32'hFFFF_FFFF, 32'h8765_4321, 1'b1, 1'b1, 16'd7);
    wait_done32("t7");
    issue32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 16'd8);
    wait_done32("t8");
    issue32(1'b1, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 1'b0, 1'b1, 16'd9);
    wait_done32("t9");

    // Reset in the middle of an operation: outputs clear at once, no done follows.
    issue32(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0, 32'h0, 1'b0, 1'b0, 16'd10);
    repeat (13) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_rst("reset_midop");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    issue32(1'b0, 32'd100, 32'd7, 32'hE, 32'h2, 1'b0, 1'b1, 16'd11);
    wait_done32("t11");

    // Back-to-back: start held high across done is accepted in the next idle cycle.
    @(negedge clk);
    sgn32 = 1'b0; a32 = 32'd1000; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk);
    e.q = 32'h8E; e.r = 32'h6; e.dz = 1'b0; e.lat = 32'd33; e.t0 = 64'($time); e.id = 16'd12;
    exp32_q.push_back(e);
    @(negedge clk);
    wait_done32("t12");
    a32 = 32'hDEAD_BEEF; b32 = 32'h10;
    e.q = 32'h0DEA_DBEE; e.r = 32'hF; e.dz = 1'b0; e.lat = 32'd33;
    e.t0 = 64'($time + 5); e.id = 16'd13;
    exp32_q.push_back(e);
    @(negedge clk);
    start32 = 1'b0;
    wait_done32("t13");

    // 8-bit instance
    issue8(1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 16'd20);
    wait_done8("t20");
    issue8(1'b0, 8'hF9, 8'h02, 8'h7C, 8'h01, 1'b0, 16'd21);
    wait_done8("t21");
    issue8(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 16'd22);
    wait_done8("t22");
    issue8(1'b0, 8'h10, 8'h00, 8'hFF, 8'h10, 1'b1, 16'd23);
    wait_done8("t23");
    issue8(1'b1, 8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b1, 16'd24);
    wait_done8("t24");

    repeat (5) @(negedge clk);
    chk("div32 pending_results", 32'(exp32_q.size()), 32'd0);
    chk("div8 pending_results", 32'(exp8_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
